// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
//   muldiv_op_t : M-extension operation encoding carried on the op port
//   is_muldiv   : true for any encoding that names an M-extension op
//   MULDIV_LAT  : accept-to-result latency of an iterating (non-special) op
package ex_muldiv_pkg;

    localparam int MD_WIDTH   = 64;
    localparam int MULDIV_LAT = MD_WIDTH + 1;

    typedef logic [MD_WIDTH-1:0] word_t;

    typedef enum logic [3:0] {
        MUL   = 4'd0,
        MULW  = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        REM   = 4'd4,
        REMU  = 4'd5,
        DIVW  = 4'd6,
        DIVUW = 4'd7,
        REMW  = 4'd8,
        REMUW = 4'd9
    } muldiv_op_t;

    function automatic logic is_muldiv(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_mul_op(input muldiv_op_t o);
        return (o == MUL) || (o == MULW);
    endfunction

    function automatic logic is_w_op(input muldiv_op_t o);
        return (o == MULW) || (o == DIVW) || (o == DIVUW) || (o == REMW) || (o == REMUW);
    endfunction

    function automatic logic is_signed_op(input muldiv_op_t o);
        return (o == MUL) || (o == MULW) || (o == DIV) || (o == REM) || (o == DIVW) || (o == REMW);
    endfunction

    function automatic logic is_rem_op(input muldiv_op_t o);
        return (o == REM) || (o == REMU) || (o == REMW) || (o == REMUW);
    endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Restoring divider core, one quotient bit per step, unsigned operands.
//   clk, reset         : clock, async active-low reset
//   start              : load dividend/divisor and clear the partial remainder
//   step               : perform one restoring iteration
//   dividend, divisor  : unsigned operands (sampled on start)
//   quotient, remainder: running results, final after WIDTH steps
//   done               : high during the step that produces the last bit
module div_iter
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Partial remainder shifted left with the next dividend bit; it can be
    // one bit wider than the divisor, hence the WIDTH+1 compare. When it fits,
    // the true difference is below the divisor so WIDTH bits suffice.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]};
        fits  = trial >= {1'b0, dvs_q};
        diff  = trial[WIDTH-1:0] - dvs_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            rem_q <= fits ? diff : trial[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], fits};
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = step && (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV64M multiply/divide unit for the execute stage.
//   clk, reset           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (ready only when idle)
//   op, srca, srcb       : M-extension op and forwarded rs1/rs2
//   flush                : abandon any in-flight op
//   out_valid/out_ready  : result handshake, result held until accepted
//   result               : final 64-bit result (zero when not valid)
//   busy                 : stall request to the hazard unit
//
// state | meaning
// IDLE  | waiting for an op, in_ready high
// BUSY  | iterating, one multiply/divide step per cycle
// DONE  | result presented, waiting for out_ready
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [WIDTH-1:0] MIN_D = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_W = {{(WIDTH-31){1'b1}}, 31'b0};

    function automatic logic [WIDTH-1:0] sext32(input logic [31:0] x);
        return {{(WIDTH-32){x[31]}}, x};
    endfunction

    logic [1:0]       state;
    logic [CNT_W-1:0] counter;
    muldiv_op_t       op_q;
    logic             special_q, q_neg_q, r_neg_q;
    logic [WIDTH-1:0] spec_res_q, acc_q, mcand_q, mplier_q;

    muldiv_op_t       op_in;
    logic             in_w, in_sgn, in_div, a_neg, b_neg;
    logic             div_by_zero, div_ovf, in_special, accept;
    logic [WIDTH-1:0] a_ext, b_ext, a_abs, b_abs, spec_raw, spec_res;

    logic             div_start, div_step, div_done, last_step;
    logic [WIDTH-1:0] div_quo, div_rem, q_fix, r_fix, raw, fin;

    assign op_in = muldiv_op_t'(op);

    // Operand preparation and detection of the divide cases that need no iteration.
    always_comb begin
        in_w   = is_w_op(op_in);
        in_sgn = is_signed_op(op_in);
        in_div = !is_mul_op(op_in);
        if (in_w) begin
            a_ext = in_sgn ? sext32(srca[31:0]) : {{(WIDTH-32){1'b0}}, srca[31:0]};
            b_ext = in_sgn ? sext32(srcb[31:0]) : {{(WIDTH-32){1'b0}}, srcb[31:0]};
        end else begin
            a_ext = srca;
            b_ext = srcb;
        end
        a_neg       = in_div && in_sgn && a_ext[WIDTH-1];
        b_neg       = in_div && in_sgn && b_ext[WIDTH-1];
        a_abs       = a_neg ? -a_ext : a_ext;
        b_abs       = b_neg ? -b_ext : b_ext;
        div_by_zero = in_div && (b_ext == '0);
        div_ovf     = in_div && in_sgn && (b_ext == '1) && (a_ext == (in_w ? MIN_W : MIN_D));
        in_special  = div_by_zero || div_ovf;
        if (div_by_zero)
            spec_raw = is_rem_op(op_in) ? a_ext : '1;
        else
            spec_raw = is_rem_op(op_in) ? '0 : a_ext;
        spec_res = in_w ? sext32(spec_raw[31:0]) : spec_raw;
    end

    // Encodings outside the M set are never taken from the producer.
    assign accept    = in_valid && (state == IDLE) && is_muldiv(op) && !flush;
    assign div_start = accept && in_div && !in_special;
    assign div_step  = (state == BUSY) && !flush && !is_mul_op(op_q);
    assign last_step = is_mul_op(op_q) ? (counter == CNT_W'(WIDTH - 1)) : div_done;

    div_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_div_iter (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .step      (div_step),
        .dividend  (a_abs),
        .divisor   (b_abs),
        .quotient  (div_quo),
        .remainder (div_rem),
        .done      (div_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            counter    <= '0;
            op_q       <= MUL;
            special_q  <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            spec_res_q <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
        end else if (flush) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q       <= op_in;
                        special_q  <= in_special;
                        spec_res_q <= spec_res;
                        q_neg_q    <= a_neg ^ b_neg;
                        r_neg_q    <= a_neg;
                        acc_q      <= '0;
                        mcand_q    <= a_ext;
                        mplier_q   <= b_ext;
                        counter    <= '0;
                        state      <= in_special ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    // Low half of the product is sign-agnostic, so plain shift-add suffices.
                    if (is_mul_op(op_q)) begin
                        if (mplier_q[0])
                            acc_q <= acc_q + mcand_q;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end
                    counter <= counter + CNT_W'(1);
                    if (last_step)
                        state <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state   <= IDLE;
                        counter <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sign fix-up and W-op narrowing are applied on the stored iteration state,
    // which stays frozen for as long as DONE is held.
    always_comb begin
        q_fix = q_neg_q ? -div_quo : div_quo;
        r_fix = r_neg_q ? -div_rem : div_rem;
        if (is_mul_op(op_q))
            raw = acc_q;
        else if (is_rem_op(op_q))
            raw = r_fix;
        else
            raw = q_fix;
        if (special_q)
            fin = spec_res_q;
        else
            fin = is_w_op(op_q) ? sext32(raw[31:0]) : raw;
        result = (state == DONE) ? fin : '0;
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [63:0] srca = '0;
    logic [63:0] srcb = '0;
    logic        in_ready, out_valid, busy;
    logic [63:0] result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(64), .CNT_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .srca      (srca),
        .srcb      (srcb),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one op for a single accept edge; returns just after that edge.
    task automatic send(input muldiv_op_t o, input logic [63:0] a, input logic [63:0] b);
        @(negedge clk);
        op = o;
        srca = a;
        srcb = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts cycles (sampled on negedges) until out_valid; -1 if it never rises.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input muldiv_op_t o, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
        int lat;
        send(o, a, b);
        wait_done(lat);
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " result"}, result, exp);
        take_result();
        chk({tag, " back to idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int pre;
        int seen;
        int unstable;

        // reset values
        repeat (2) @(negedge clk);
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset result", result, 64'd0);
        reset = 1'b1;

        // iterating ops: latency WIDTH+1
        run_op("MUL 7*-3", MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MULDIV_LAT);
        run_op("DIVU 100/7", DIVU, 64'd100, 64'd7, 64'd14, 65);
        run_op("REMU 100%7", REMU, 64'd100, 64'd7, 64'd2, 65);
        run_op("DIV -100/7", DIV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65);
        run_op("REM -100%7", REM, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("MULW 7fffffff*2", MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        run_op("REMW -7%2", REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        run_op("DIVW trunc 100/-7", DIVW, 64'h1234_5678_0000_0064, 64'h0000_0000_FFFF_FFF9,
               64'hFFFF_FFFF_FFFF_FFF2, 65);
        run_op("DIVUW ffffffff/1", DIVUW, 64'hDEAD_BEEF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65);

        // special cases: result one cycle after accept
        run_op("DIV 1/0", DIV, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_op("REM -5%0", REM, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1);
        run_op("REMU 5%0", REMU, 64'd5, 64'd0, 64'd5, 1);
        run_op("DIV min/-1", DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1);
        run_op("REM min%-1", REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
        run_op("DIVW min/-1", DIVW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1);

        // flush in the tenth busy cycle: back to idle next cycle, no result
        send(DIV, 64'd100, 64'd7);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        chk("flush busy before", 64'(busy), 64'd1);
        chk("flush in_ready before", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush idle in_ready", 64'(in_ready), 64'd1);
        chk("flush idle busy", 64'(busy), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush no out_valid", 64'(seen), 64'd0);

        // in_valid ignored while busy, result held under back-pressure
        send(DIVU, 64'd100, 64'd7);
        repeat (5) @(negedge clk);
        op = MUL;
        srca = 64'd3;
        srcb = 64'd3;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        pre = 8;
        wait_done(lat);
        chk("busy-ignore latency", 64'(pre + lat), 64'd65);
        chk("busy-ignore result", result, 64'd14);
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!out_valid || result !== 64'd14) unstable++;
        end
        chk("hold stable", 64'(unstable), 64'd0);

        // completion and a new request in the same cycle: new op waits a cycle
        out_ready = 1'b1;
        in_valid = 1'b1;
        op = MUL;
        srca = 64'd3;
        srcb = 64'd5;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("done+in_valid idle", 64'(in_ready), 64'd1);
        chk("done+in_valid out_valid", 64'(out_valid), 64'd0);
        chk("done+in_valid busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("late accept busy", 64'(busy), 64'd1);
        wait_done(lat);
        chk("late accept latency", 64'(lat), 64'd65);
        chk("late accept result", result, 64'd15);
        take_result();

        // async reset while busy
        send(MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD);
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async rst in_ready", 64'(in_ready), 64'd1);
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst busy", 64'(busy), 64'd0);
        chk("async rst result", result, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op("post-reset DIVU", DIVU, 64'd100, 64'd7, 64'd14, 65);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
